// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
//   Shared types and helpers for the counter scheduler.
//   - sched_state_t : FSM states of the job sequencer
//   - id_width()    : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package counter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sched_state_t;

  // Index width for n requesters. A single-bit index is kept as a floor so
  // that port and register widths never collapse to zero.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : counter_sched_pkg

// File: rtl/counter_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at i_last+1 and wraps,
//   so the most recent winner has the lowest priority.
//
//   Ports
//     i_req    : per-requester request vector
//     i_last   : index of the previous winner
//     o_onehot : one-hot winner (all zero when nothing is requested)
//     o_idx    : binary winner index (0 when nothing is requested)
//     o_valid  : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  logic [ID_W-1:0] w_cand;

  // NOTE: every output of a combinational block is given a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = ID_W'((int'(i_last) + off) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule : rr_arbiter

// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
//   Shares one up/down counter among NUM_REQ requesters. A round-robin arbiter
//   picks one job at a time; the job loads the counter, steps it len times in
//   its requested direction and reports completion with a one-cycle done pulse.
//
//   Ports
//     clk      : clock, rising edge
//     reset    : asynchronous active-low reset
//     req      : per-requester job request (level)
//     req_init : packed start values, requester i at [i*WIDTH +: WIDTH]
//     req_dir  : per-requester direction, 1 = up, 0 = down
//     req_len  : packed step counts, requester i at [i*LEN_W +: LEN_W]
//     abort    : end the current job early (honoured in LOAD and RUN)
//     grant    : one-hot acknowledge, high for the LOAD cycle only
//     busy     : a job is in progress
//     count    : live counter value
//     done     : one-cycle job-complete pulse
//     done_id  : index of the finished job
//     aborted  : qualifies done, the job ended through abort
// -----------------------------------------------------------------------------
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  parameter  int LEN_W   = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_init,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic                     aborted
);

  sched_state_t r_state;
  sched_state_t w_next_state;

  logic [WIDTH-1:0] r_count;
  logic [LEN_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_init;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [ID_W-1:0]  r_winner;
  logic [ID_W-1:0]  r_last_winner;
  logic             r_aborted;

  logic [NUM_REQ-1:0] w_arb_onehot;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_arb_valid;
  logic [WIDTH-1:0]   w_count_step;
  logic [WIDTH-1:0]   w_sel_init;
  logic [LEN_W-1:0]   w_sel_len;
  logic               w_sel_dir;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req    (req),
    .i_last   (r_last_winner),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  // Fields of the requester the arbiter is currently pointing at.
  assign w_sel_init = req_init[int'(w_arb_idx)*WIDTH +: WIDTH];
  assign w_sel_len  = req_len[int'(w_arb_idx)*LEN_W +: LEN_W];
  assign w_sel_dir  = req_dir[w_arb_idx];

  // Arithmetic wraps modulo 2^WIDTH by truncation.
  assign w_count_step = r_dir ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort || (r_len == '0)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        // Leave on the edge that takes remaining from 1 to 0.
        if (abort || (r_remaining == LEN_W'(1))) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers and counter datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count       <= '0;
      r_remaining   <= '0;
      r_init        <= '0;
      r_dir         <= 1'b0;
      r_len         <= '0;
      r_winner      <= '0;
      // Pointer at the last requester gives requester 0 first priority.
      r_last_winner <= ID_W'(NUM_REQ - 1);
      r_aborted     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Job fields are captured here so later req changes cannot disturb
          // the job once it has been accepted.
          if (w_arb_valid) begin
            r_init    <= w_sel_init;
            r_dir     <= w_sel_dir;
            r_len     <= w_sel_len;
            r_winner  <= w_arb_idx;
            r_aborted <= 1'b0;
          end
        end
        S_LOAD: begin
          // The counter takes init even when the job is aborted here.
          r_count     <= r_init;
          r_remaining <= r_len;
          if (abort) begin
            r_aborted <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_aborted <= 1'b1;
          end else begin
            r_count     <= w_count_step;
            r_remaining <= r_remaining - LEN_W'(1);
          end
        end
        S_DONE: begin
          r_last_winner <= r_winner;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = '0;
    if (r_state == S_LOAD) begin
      grant[r_winner] = 1'b1;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign done_id = r_winner;
  assign aborted = done & r_aborted;
  assign count   = r_count;

endmodule : counter_scheduler

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_scheduler
//   Self-checking bench for counter_scheduler. The reference model works at
//   job level: a round-robin pointer chooses the winner, and the expected
//   counter value at each cycle of a job is init +/- elapsed steps modulo 16.
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 2;
  localparam int MOD     = 1 << WIDTH;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_init = '0;
  logic [NUM_REQ-1:0]       req_dir = '0;
  logic [NUM_REQ*LEN_W-1:0] req_len = '0;
  logic                     abort = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic                     aborted;

  int errors = 0;
  int checks = 0;
  int job_no = 0;

  // Reference model state
  int last_w = NUM_REQ - 1;
  int m_init [NUM_REQ];
  int m_dir  [NUM_REQ];
  int m_len  [NUM_REQ];

  always #5 clk = ~clk;

  counter_scheduler #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_init (req_init),
    .req_dir  (req_dir),
    .req_len  (req_len),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done),
    .done_id  (done_id),
    .aborted  (aborted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int init, input int dir, input int len);
    m_init[i] = init;
    m_dir[i]  = dir;
    m_len[i]  = len;
    req_init[i*WIDTH +: WIDTH] = WIDTH'(init);
    req_dir[i]                 = dir[0];
    req_len[i*LEN_W +: LEN_W]  = LEN_W'(len);
    req[i]                     = 1'b1;
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last_w + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int exp_count(input int init, input int dir, input int n);
    int v;
    v = dir ? (init + n) : (init - n);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  // Runs one job from an IDLE cycle with req already set. abort_at = -1 means
  // no abort, 0 means abort during LOAD, k means abort during RUN cycle k.
  // Ends in the IDLE cycle after done, with the winner's req dropped.
  task automatic do_job(input int abort_at);
    int  w, len, steps, done_at, n;
    bit  ab;
    w       = pick(req);
    len     = m_len[w];
    ab      = (abort_at >= 0) && (abort_at <= len);
    done_at = ab ? abort_at + 2 : len + 2;
    steps   = ab ? ((abort_at > 0) ? abort_at - 1 : 0) : len;
    job_no++;

    step();  // LOAD cycle
    check($sformatf("job%0d.grant", job_no), grant, 32'(1) << w);
    check($sformatf("job%0d.busy_load", job_no), busy, 1);
    check($sformatf("job%0d.done_load", job_no), done, 0);
    req[w] = 1'b0;

    for (int m = 2; m <= done_at; m++) begin
      abort = ab && (m == done_at);
      step();
      abort = 1'b0;
      n = (m - 2 < steps) ? m - 2 : steps;
      check($sformatf("job%0d.count_c%0d", job_no, m), count, exp_count(m_init[w], m_dir[w], n));
      check($sformatf("job%0d.busy_c%0d", job_no, m), busy, 1);
      check($sformatf("job%0d.done_c%0d", job_no, m), done, (m == done_at));
      if (m == 2) check($sformatf("job%0d.grant_off", job_no), grant, 0);
      if (m == done_at) begin
        check($sformatf("job%0d.done_id", job_no), done_id, w);
        check($sformatf("job%0d.aborted", job_no), aborted, ab);
      end
    end

    step();  // IDLE cycle
    check($sformatf("job%0d.busy_idle", job_no), busy, 0);
    check($sformatf("job%0d.done_idle", job_no), done, 0);
    check($sformatf("job%0d.count_hold", job_no), count, exp_count(m_init[w], m_dir[w], steps));
    last_w = w;
  endtask

  initial begin
    int w, len_w, ab_at;

    // ---- reset state ----
    #12;
    check("rst.count", count, 0);
    check("rst.busy", busy, 0);
    check("rst.grant", grant, 0);
    check("rst.done", done, 0);
    check("rst.done_id", done_id, 0);
    check("rst.aborted", aborted, 0);
    reset = 1'b1;
    step();

    // ---- single job, up ----
    set_req(0, 3, 1, 4);
    do_job(-1);

    // ---- wrap-around up, then down ----
    set_req(1, 14, 1, 3);
    do_job(-1);
    set_req(1, 1, 0, 3);
    do_job(-1);

    // ---- round-robin fairness: all requesting, winner re-raises after done ----
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, $urandom_range(0, MOD - 1), $urandom_range(0, 1), $urandom_range(0, 3));
    end
    for (int j = 0; j < 5; j++) begin
      do_job(-1);
      req[last_w] = 1'b1;
    end
    req = '0;
    step();
    step();
    check("idle.count_hold", count, exp_count(m_init[last_w], m_dir[last_w], m_len[last_w]));
    check("idle.busy", busy, 0);

    // ---- len = 0 ----
    set_req(3, 9, 1, 0);
    do_job(-1);

    // ---- abort in third RUN cycle, then abort during LOAD ----
    set_req(0, 5, 1, 10);
    do_job(3);
    set_req(2, 6, 0, 5);
    do_job(0);

    // ---- reset mid-RUN (last completed winner is 2) ----
    set_req(0, 5, 1, 12);
    step();
    check("rstmid.grant", grant, 4'b0001);
    req[0] = 1'b0;
    step();
    step();
    step();
    check("rstmid.count_run", count, 7);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid.count", count, 0);
    check("rstmid.busy", busy, 0);
    check("rstmid.done", done, 0);
    set_req(2, 10, 0, 2);
    set_req(3, 4, 1, 2);
    for (int j = 0; j < 3; j++) begin
      step();
      check("rstmid.no_done", done, 0);
    end
    reset = 1'b1;
    last_w = NUM_REQ - 1;
    do_job(-1);  // pointer restarted: requester 2 wins over 3
    check("rstmid.winner", last_w, 2);
    do_job(-1);

    // ---- randomized jobs ----
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          set_req(i, $urandom_range(0, MOD - 1), $urandom_range(0, 1), $urandom_range(0, 15));
        end
      end
      if (req == '0) begin
        set_req($urandom_range(0, NUM_REQ - 1), $urandom_range(0, MOD - 1),
                $urandom_range(0, 1), $urandom_range(0, 15));
      end
      w     = pick(req);
      len_w = m_len[w];
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len_w)) : -1;
      do_job(ab_at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule : tb_counter_scheduler

// File: doc/counter_scheduler.md
# counter_scheduler

Shares one up/down counter datapath among NUM_REQ requesters. Each requester asks for a counting job (start value, direction, step count). A round-robin arbiter grants one job at a time, loads the counter, steps it the requested number of cycles and returns the final value with a done pulse. It sits between client blocks and the counter, and replaces direct per-client control of load/direction.

## Interface
- WIDTH, 4, counter width in bits
- NUM_REQ, 4, number of requesters (2..8)
- LEN_W, 4, width of the step-count field
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester job request, level
- req_init  input  NUM_REQ×WIDTH  start value per requester
- req_dir  input  NUM_REQ  direction per requester: 1 = up, 0 = down
- req_len  input  NUM_REQ×LEN_W  number of steps per requester
- abort  input  1  terminate the current job early
- grant  output  NUM_REQ  one-hot, one-cycle acknowledge of the accepted job
- busy  output  1  a job is in progress (state ≠ IDLE)
- count  output  WIDTH  live counter value
- done  output  1  one-cycle job-complete pulse
- done_id  output  $clog2(NUM_REQ)  index of the finished job
- aborted  output  1  qualifies done: the job ended via abort

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any req bit is set, pick a winner by round-robin, starting the search at last_winner+1 and wrapping.
  - Latch the winner's init, dir, len and index, then go to LOAD.
  - With no req, stay in IDLE; count holds its value.
- **LOAD**
  - grant[winner]=1 for this cycle only; count←init; remaining←len.
  - If len=0, go to DONE; otherwise go to RUN.
- **RUN**
  - Each cycle: count←count±1 (modulo 2^WIDTH, so wrap is legal: F+1→0, 0−1→F for WIDTH=4); remaining←remaining−1.
  - Go to DONE on the edge that makes remaining 0.
- **DONE**
  - done=1 for one cycle, with done_id=winner and aborted per job; count holds the final value.
  - last_winner←winner; go to IDLE.
- **abort**
  - Sampled in LOAD or RUN; go to DONE next edge with aborted=1.
  - count freezes at its current value (in LOAD it still takes init).
  - Ignored in IDLE and DONE.
- **Requester obligations**
  - Hold req and its fields stable until grant.
  - Drop req the cycle after grant, or the job is rerun.
  - req changes outside this window have no effect on the running job.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, count=0, grant=0, busy=0, done=0, done_id=0, aborted=0, last_winner=NUM_REQ−1 (so req[0] has first priority).
- Reset asserted mid-job discards the job with no done pulse.
- Cycle sequence for a request seen in IDLE at cycle T:
  - T+1: grant and LOAD.
  - T+2: count=init.
  - T+2..T+1+len: RUN.
  - T+2+len: done, with count=init±len.
- len=0: done at T+2 with count=init.
- busy is high from T+1 through the done cycle inclusive.
- Minimum gap between jobs: DONE→IDLE→LOAD, so back-to-back grants are len+3 cycles apart.
- Simultaneous requests: only one grant per job; losers wait.
- A requester asserting req in the DONE cycle is arbitrated in the following IDLE cycle.

## Structure
- Package counter_sched_pkg holds:
  - typedef sched_state_t, the enum for IDLE/LOAD/RUN/DONE
  - the ID width function/localparam
- Sub-module rr_arbiter:
  - combinational one-hot round-robin pick from req and last_winner
  - parameterized by NUM_REQ
- Counter register, remaining counter and FSM live in counter_scheduler.

## Test plan
- Single job: req[0], init=3, dir=up, len=4 → grant[0] at T+1; count 3,4,5,6,7; done at T+6, count=7, done_id=0.
- Wrap-around: req[1], init=E, down=0→up, len=3 → count E,F,0,1; done count=1. Down from 1, len=3 → 1,0,F,E.
- Round-robin fairness: req=4'b1111 held (each dropped after its grant, then re-raised) → grant order 0,1,2,3,0; no requester granted twice before all others.
- len=0 and abort:
  - len=0, init=9 → done at T+2 with count=9.
  - len=10 with abort pulsed in the third RUN cycle → done next cycle, aborted=1, count frozen.
- Reset mid-RUN: drop reset during RUN → immediately count=0, busy=0, no done. After release, pending req[2] is granted; priority pointer is back at 0.
